// File: rtl/sdpram_bist.sv
// sdpram_bist: built-in self test for a simple dual-port RAM.
// Writes a pattern over the full depth, reads it back and counts mismatches.
module sdpram_bist #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [DATA_WIDTH-1:0]    mem_wr_data,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LI    = RD_LATENCY - 1;
    localparam logic [ADDR_WIDTH:0] LAST    = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DR_LAST = (ADDR_WIDTH+1)'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH:0]     cnt, cnt_nx;
    logic                    clr;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   pat_cur;
    logic [RD_LATENCY-1:0]   vld;
    logic [DATA_WIDTH-1:0]   exp_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   adr_q [RD_LATENCY];
    logic                    mism;

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [1:0]            m,
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
        logic [DATA_WIDTH-1:0]            alt;
        ext = {{DATA_WIDTH{1'b0}}, a};
        for (int i = 0; i < DATA_WIDTH; i++) alt[i] = (i % 2 == 0);
        if (a[0]) alt = ~alt;
        unique case (m)
            2'd0:    pat = ~ext[DATA_WIDTH-1:0];
            2'd1:    pat = ext[DATA_WIDTH-1:0];
            2'd2:    pat = alt;
            default: pat = ~alt;
        endcase
    endfunction

    assign addr    = cnt[ADDR_WIDTH-1:0];
    assign pat_cur = pat(mode_q, addr);

    // state, shared address/drain counter and latched mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mode_q <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (clr) mode_q <= mode;
        end
    end

    // sequencing: write sweep, one idle gap, read sweep, pipeline drain
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr      = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_WRITE;
                    cnt_nx   = '0;
                    clr      = 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt == LAST) begin
                    state_nx = S_GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            S_GAP: state_nx = S_READ;
            S_READ: begin
                if (cnt == LAST) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            S_DRAIN: begin
                if (cnt == DR_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy        = (state == S_WRITE) || (state == S_GAP) ||
                         (state == S_READ)  || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign pass        = done && (err_cnt == '0);
    assign mem_wr_en   = (state == S_WRITE);
    assign mem_wr_addr = mem_wr_en ? addr : '0;
    assign mem_wr_data = mem_wr_en ? pat_cur : '0;
    assign mem_rd_en   = (state == S_READ);
    assign mem_rd_addr = mem_rd_en ? addr : '0;

    // first stage of the expected-data pipeline, launched with each read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld[0]   <= 1'b0;
            exp_q[0] <= '0;
            adr_q[0] <= '0;
        end else begin
            vld[0]   <= mem_rd_en;
            exp_q[0] <= pat_cur;
            adr_q[0] <= addr;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            // extra stage matching a registered memory output
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld[1]   <= 1'b0;
                    exp_q[1] <= '0;
                    adr_q[1] <= '0;
                end else begin
                    vld[1]   <= vld[0];
                    exp_q[1] <= exp_q[0];
                    adr_q[1] <= adr_q[0];
                end
            end
        end
    endgenerate

    assign mism = vld[LI] && (mem_rd_data != exp_q[LI]);

    // saturating error count and sticky first failing address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (clr) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mism) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
            if (err_cnt == '0) first_err_addr <= adr_q[LI];
        end
    end

endmodule

// File: doc/sdpram_bist.md
SDPRAM_BIST -- requirements
Module: sdpram_bist

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory address width (depth 2^ADDR_WIDTH), legal range 4..20.
- REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width, legal range 2..1152.
- REQ-003 SHALL have parameter RD_LATENCY, default 1, memory read latency in cycles (1 = no output register, 2 = output register), legal values 1 and 2.
- REQ-004 SHALL have parameter ERR_CNT_WIDTH, default 3, width of the saturating error counter.
- REQ-005 SHALL have port clk, input, 1 bit, single clock for all logic and the memory under test.
- REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
- REQ-007 SHALL have port start, input, 1 bit, run request, sampled in IDLE/DONE only.
- REQ-008 SHALL have port mode, input, 2 bits, data pattern select, latched on accepted start.
- REQ-009 SHALL have port busy, output, 1 bit, high from the first WRITE cycle through the last DRAIN cycle.
- REQ-010 SHALL have port done, output, 1 bit, level high in DONE.
- REQ-011 SHALL have port pass, output, 1 bit, equal to done AND err_cnt==0.
- REQ-012 SHALL have port err_cnt, output, ERR_CNT_WIDTH bits, saturating mismatch count.
- REQ-013 SHALL have port first_err_addr, output, ADDR_WIDTH bits, read address of the first mismatch.
- REQ-014 SHALL have ports mem_wr_en (1), mem_wr_addr (ADDR_WIDTH) and mem_wr_data (DATA_WIDTH), all outputs, forming the memory write port.
- REQ-015 SHALL have ports mem_rd_en (1) and mem_rd_addr (ADDR_WIDTH), outputs, and mem_rd_data (DATA_WIDTH), input, forming the memory read port.

Function
- REQ-016 SHALL implement the states IDLE, WRITE, GAP, READ, DRAIN and DONE.
- REQ-017 IDLE/DONE: start=1 SHALL latch mode, clear err_cnt and first_err_addr, and enter WRITE at the next edge; start SHALL be ignored in all other states.
- REQ-018 WRITE: mem_wr_en=1 SHALL be asserted with mem_wr_addr stepping 0..2^ADDR_WIDTH-1, one per cycle; after the last address the state SHALL go to GAP.
- REQ-019 GAP SHALL last 1 cycle with mem_wr_en=0 and mem_rd_en=0, then go to READ.
- REQ-020 READ: mem_rd_en=1 SHALL be asserted with mem_rd_addr stepping 0..2^ADDR_WIDTH-1; after the last address the state SHALL go to DRAIN.
- REQ-021 DRAIN SHALL last RD_LATENCY cycles, then go to DONE.
- REQ-022 Total busy time SHALL be 2*2^ADDR_WIDTH + 1 + RD_LATENCY cycles.
- REQ-023 Pattern at address a SHALL be:
  - mode 0: all-ones minus a (mod 2^DATA_WIDTH), i.e. down-count;
  - mode 1: a, truncated or zero-extended to DATA_WIDTH;
  - mode 2: 0101..01 for even a, 1010..10 for odd a;
  - mode 3: the bitwise inverse of mode 2.
- REQ-024 Expected data and address SHALL be delayed RD_LATENCY cycles alongside a valid flag, and mem_rd_data SHALL be compared in the cycle it is valid.
- REQ-025 On a mismatch, err_cnt SHALL increment at the following edge and saturate at 2^ERR_CNT_WIDTH-1.
- REQ-026 On the first mismatch of a run, first_err_addr SHALL capture that read address; later mismatches SHALL NOT overwrite it.
- REQ-027 The compare of the final read address SHALL be committed on the same edge that enters DONE, so err_cnt is final when done rises.
- REQ-028 mem_wr_en and mem_rd_en SHALL be 0 outside WRITE and READ respectively.
- REQ-029 Address counters SHALL be ADDR_WIDTH+1 bits internally so the terminal count is detected without wrap aliasing.

Reset
- REQ-030 While rst=1, asynchronously: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, all mem_* outputs 0, pipeline valid flags 0.
- REQ-031 Reset asserted mid-run SHALL abort immediately with no further memory writes; a start after release SHALL begin a fresh run from address 0.

Verification
- REQ-032 Defaults, ideal memory, mode 0: addr0=0xFF, addr1=0xFE, addr255=0x00, addr256=0xFF -> busy for 8194 cycles, done=1, pass=1, err_cnt=0.
- REQ-033 Memory model flips bit 0 of the read at 0x123, mode 1 -> err_cnt=1, first_err_addr=0x123, pass=0.
- REQ-034 mem_rd_data stuck at 0x00, mode 2 -> err_cnt saturates at 7, first_err_addr=0x000, pass=0.
- REQ-035 rst pulse when mem_wr_addr=100 -> next cycle busy=0 and mem_wr_en=0; restart in mode 3 -> pass=1.
- REQ-036 RD_LATENCY=2 with a registered-output model, mode 0 -> 8195 busy cycles, pass=1; start pulsed during busy -> no effect on sequence or counts.
